corrupt_channel: RTL

Parametrised channel-error injector for the Reed-Muller (1,4) FPGA link. It sits between the RM encoder output and the decoder input. Each accepted codeword is XORed with a selectable error mask: none, a fixed pattern, or LFSR noise with bit-error probability 2^-k (k = 1..5). An optional cap limits errors per word. Valid/ready handshakes sit on both sides, and saturating statistics counters report words and flipped bits for BER measurement.

---
 rtl/corrupt_channel.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/corrupt_channel.sv
// Channel-error injector for the RM(1,4) link: XORs each codeword with
// a none/fixed/LFSR-noise mask, optionally capped, and keeps BER stats.
`timescale 1ns/1ps
module corrupt_channel #(
  parameter int          WIDTH     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE11234,
  parameter int          CNT_W     = 16,
  parameter int          CAP_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CAP_W-1:0] max_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] err_mask,
  output logic [CAP_W-1:0] err_count,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] total_words,
  output logic [CNT_W-1:0] total_flips
);

  localparam logic [31:0] SEED =
    (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam int SUM_W = ((CNT_W > CAP_W) ? CNT_W : CAP_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX =
    SUM_W'({CNT_W{1'b1}});

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  function automatic logic [CAP_W-1:0] popcnt(
    input logic [WIDTH-1:0] v
  );
    logic [CAP_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + CAP_W'(v[i]);
    return c;
  endfunction

  logic [1:0]       r_state;
  logic [31:0]      r_lfsr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_mask;
  logic [CAP_W-1:0] r_errcnt;
  logic [CAP_W-1:0] r_maxerr;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_words;
  logic [CNT_W-1:0] r_flips;

  logic [31:0]      w_lfsr_next;
  logic [WIDTH-1:0] w_rnd;
  logic [WIDTH-1:0] w_cap;
  logic [CAP_W-1:0] w_cap_n;
  logic             w_is_rand;
  logic             w_is_fix;
  logic             w_hs;
  logic [SUM_W-1:0] w_words_sum;
  logic [SUM_W-1:0] w_flips_sum;

  // WIDTH Galois steps per clock so every random word is fresh
  always_comb begin
    w_lfsr_next = r_lfsr;
    for (int i = 0; i < WIDTH; i++)
      w_lfsr_next = {1'b0, w_lfsr_next[31:1]} ^
                    (w_lfsr_next[0] ? POLY : 32'd0);
  end

  assign w_rnd = w_lfsr_next[WIDTH-1:0];

  // Keep the lowest-indexed max_err set bits; w_cap_n is their count
  always_comb begin
    w_cap   = '0;
    w_cap_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_mask[i] &&
          (r_maxerr == '0 || w_cap_n < r_maxerr)) begin
        w_cap[i] = 1'b1;
        w_cap_n  = w_cap_n + CAP_W'(1);
      end
    end
  end

  assign w_is_rand = (mode >= 3'd2) && (mode <= 3'd6);
  assign w_is_fix  = (mode == 3'd1);
  assign w_hs      = (r_state == S_OUT) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_data   <= '0;
      r_mask   <= '0;
      r_errcnt <= '0;
      r_maxerr <= '0;
      r_cnt    <= '0;
    end else begin
      r_lfsr <= w_lfsr_next;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data   <= in_data;
            r_maxerr <= max_err;
            unique case (1'b1)
              w_is_rand: begin
                r_mask  <= '1;
                r_cnt   <= mode - 3'd1;
                r_state <= S_GEN;
              end
              w_is_fix: begin
                r_mask   <= pattern;
                r_errcnt <= popcnt(pattern);
                r_state  <= S_OUT;
              end
              default: begin
                r_mask   <= '0;
                r_errcnt <= '0;
                r_state  <= S_OUT;
              end
            endcase
          end
        end
        S_GEN: begin
          r_mask <= r_mask & w_rnd;
          r_cnt  <= r_cnt - 3'd1;
          if (r_cnt == 3'd1)
            r_state <= S_CAP;
        end
        S_CAP: begin
          r_mask   <= w_cap;
          r_errcnt <= w_cap_n;
          r_state  <= S_OUT;
        end
        S_OUT: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_words_sum = SUM_W'(r_words) + SUM_W'(1);
  assign w_flips_sum = SUM_W'(r_flips) + SUM_W'(r_errcnt);

  // Clear beats a coincident handshake
  always_ff @(posedge clk) begin
    if (!rst || clr_stats) begin
      r_words <= '0;
      r_flips <= '0;
    end else if (w_hs) begin
      r_words <= (w_words_sum > CNT_MAX) ?
                 '1 : w_words_sum[CNT_W-1:0];
      r_flips <= (w_flips_sum > CNT_MAX) ?
                 '1 : w_flips_sum[CNT_W-1:0];
    end
  end

  assign in_ready    = rst && (r_state == S_IDLE);
  assign out_valid   = (r_state == S_OUT);
  assign out_data    = r_data ^ r_mask;
  assign err_mask    = r_mask;
  assign err_count   = r_errcnt;
  assign total_words = r_words;
  assign total_flips = r_flips;

endmodule
